// File: rtl/pwm_pkg.sv
// Shared constants for the PWM blocks on the 50 MHz board clock.
package pwm_pkg;

  localparam int CLK_HZ      = 50_000_000;
  localparam int CTR_DEFAULT = 16;

  function automatic int unsigned cycles_to_us(input int unsigned cycles);
    return cycles / (CLK_HZ / 1_000_000);
  endfunction

endpackage

// File: rtl/pwm_capture_if.sv
// Measurement bundle of pwm_capture: the PWM pin in, width/period/status out.
interface pwm_capture_if
  import pwm_pkg::*;
#(
  parameter int CTR = CTR_DEFAULT
);

  // valid is a one-cycle strobe with no ready: width/period change only on
  // that cycle and are held afterwards, so a consumer may sample them on the
  // strobe or any later cycle before the next strobe.
  logic           sig;
  logic [CTR-1:0] width;
  logic [CTR-1:0] period;
  logic           valid;
  logic           timeout;
  logic           level;
  logic [1:0]     state;

  modport master (
    input  sig,
    output width, period, valid, timeout, level, state
  );

  modport slave (
    output sig,
    input  width, period, valid, timeout, level, state
  );

endinterface

// File: rtl/sig_sync.sv
// Two-flop synchronizer for the asynchronous PWM pin plus rise/fall detection.
module sig_sync (
  input  logic clk,
  input  logic rst,
  input  logic sig,
  output logic level,
  output logic rise,
  output logic fall,
  output logic primed
);

  logic       s1;
  logic       s2;
  logic       s3;
  logic [1:0] fill;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1   <= 1'b0;
      s2   <= 1'b0;
      s3   <= 1'b0;
      fill <= 2'b00;
    end else begin
      s1   <= sig;
      s2   <= s1;
      s3   <= s2;
      fill <= {fill[0], 1'b1};
    end
  end

  // primed marks that s2 now carries a real pin sample rather than reset zeros
  assign primed = fill[1];
  assign level  = s2;
  assign rise   = s2 & ~s3;
  assign fall   = ~s2 & s3;

endmodule

// File: rtl/pwm_capture.sv
// PWM input meter: high time and rise-to-rise period in clk cycles, with stall timeout.
module pwm_capture
  import pwm_pkg::*;
#(
  parameter int CTR = CTR_DEFAULT
) (
  input  logic           clk,
  input  logic           rst,
  pwm_capture_if.master  bus
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ARM  = 2'd1;
  localparam logic [1:0] HIGH = 2'd2;
  localparam logic [1:0] LOW  = 2'd3;

  localparam logic [CTR-1:0] CNT_MAX = '1;
  localparam logic [CTR-1:0] CNT_ONE = CTR'(1);

  logic level;
  logic rise;
  logic fall;
  logic primed;

  sig_sync u_sync (
    .clk    (clk),
    .rst    (rst),
    .sig    (bus.sig),
    .level  (level),
    .rise   (rise),
    .fall   (fall),
    .primed (primed)
  );

  logic [1:0]     state_q,   state_d;
  logic [CTR-1:0] cnt_q,     cnt_d;
  logic [CTR-1:0] hi_q,      hi_d;
  logic [CTR-1:0] width_q,   width_d;
  logic [CTR-1:0] period_q,  period_d;
  logic           valid_q,   valid_d;
  logic           timeout_q, timeout_d;
  logic           sat;
  logic [CTR-1:0] cnt_inc;

  assign sat     = (cnt_q == CNT_MAX);
  assign cnt_inc = sat ? cnt_q : cnt_q + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (primed && !level) state_d = ARM;
      ARM:  if (rise)             state_d = HIGH;
      HIGH: begin
        if (fall)     state_d = LOW;
        else if (sat) state_d = IDLE;
      end
      LOW: begin
        if (rise)     state_d = HIGH;
        else if (sat) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // An edge on the saturation cycle wins, so the measurement still completes.
  always_comb begin
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    width_d   = width_q;
    period_d  = period_q;
    valid_d   = 1'b0;
    timeout_d = timeout_q;
    case (state_q)
      IDLE: cnt_d = '0;
      ARM:  if (rise) cnt_d = CNT_ONE;
      HIGH: begin
        if (fall) begin
          hi_d  = cnt_q;
          cnt_d = cnt_inc;
        end else if (sat) begin
          timeout_d = 1'b1;
          cnt_d     = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      LOW: begin
        if (rise) begin
          width_d   = hi_q;
          period_d  = cnt_q;
          valid_d   = 1'b1;
          timeout_d = 1'b0;
          cnt_d     = CNT_ONE;
        end else if (sat) begin
          timeout_d = 1'b1;
          cnt_d     = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: cnt_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      hi_q      <= '0;
      width_q   <= '0;
      period_q  <= '0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      width_q   <= width_d;
      period_q  <= period_d;
      valid_q   <= valid_d;
      timeout_q <= timeout_d;
    end
  end

  assign bus.width   = width_q;
  assign bus.period  = period_q;
  assign bus.valid   = valid_q;
  assign bus.timeout = timeout_q;
  assign bus.level   = level;
  assign bus.state   = state_q;

endmodule
